// File: rtl/freq_lock_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_lock_meter
// Purpose  : Gated multi-channel zero-crossing frequency meter with lock
//            detection of every channel against channel 0.
// Revision : 1.0  initial release
// ============================================================================
module freq_lock_meter #(
   parameter int DATA_WIDTH  = 14,
   parameter int CHANNELS    = 2,
   parameter int COUNT_WIDTH = 32,
   parameter int GATE_CYCLES = 1000000,
   parameter int HYST        = 64,
   parameter int LOCK_TOL    = 2,
   parameter int LOCK_GATES  = 4
) (
   input  logic                            clock,
   input  logic                            Reset,
   input  logic                            enable,
   input  logic [CHANNELS*DATA_WIDTH-1:0]  sample_in,
   output logic [CHANNELS*COUNT_WIDTH-1:0] freq_count,
   output logic                            count_valid,
   output logic [CHANNELS-1:0]             overflow,
   output logic                            locked,
   output logic                            lock_lost
);

   localparam int c_gate_w   = $clog2(GATE_CYCLES);
   localparam int c_streak_w = $clog2(LOCK_GATES + 1);

   localparam logic [c_gate_w-1:0]          c_gate_last   = c_gate_w'(GATE_CYCLES - 1);
   localparam logic [c_streak_w-1:0]        c_streak_full = c_streak_w'(LOCK_GATES);
   localparam logic [COUNT_WIDTH-1:0]       c_cnt_max     = '1;
   localparam logic [COUNT_WIDTH:0]         c_tol         = (COUNT_WIDTH+1)'(LOCK_TOL);
   localparam logic signed [DATA_WIDTH-1:0] c_pos_th      = DATA_WIDTH'(HYST);
   localparam logic signed [DATA_WIDTH-1:0] c_neg_th      = DATA_WIDTH'(-HYST);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_MEASURE = 2'd2
   } state_t;

   state_t                                  r_state;
   logic [CHANNELS*DATA_WIDTH-1:0]          r_sample;
   logic [c_gate_w-1:0]                     r_gate_cnt;
   logic [c_streak_w-1:0]                   r_streak;
   logic [CHANNELS-1:0]                     r_arm;
   logic [CHANNELS-1:0]                     r_ovf;
   logic [CHANNELS-1:0][COUNT_WIDTH-1:0]    r_acc;

   logic [CHANNELS-1:0]                     w_arm_nxt;
   logic [CHANNELS-1:0]                     w_ovf_nxt;
   logic [CHANNELS-1:0]                     w_match;
   logic [CHANNELS-1:0][COUNT_WIDTH-1:0]    w_acc_nxt;
   logic                                    w_gate_end;
   logic                                    w_pass;
   logic [c_streak_w-1:0]                   w_streak_nxt;

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
         logic signed [DATA_WIDTH-1:0] w_smp;
         logic                         w_low;
         logic                         w_high;
         logic                         w_cross;

         assign w_smp   = r_sample[i*DATA_WIDTH +: DATA_WIDTH];
         assign w_low   = (w_smp <= c_neg_th);
         assign w_high  = (w_smp >= c_pos_th);
         assign w_cross = r_arm[i] & w_high;

         // Between the thresholds the arm flag simply holds.
         assign w_arm_nxt[i] = w_low | (r_arm[i] & ~w_high);
         assign w_ovf_nxt[i] = r_ovf[i] | (w_cross & (r_acc[i] == c_cnt_max));
         assign w_acc_nxt[i] = (w_cross && (r_acc[i] != c_cnt_max))
                               ? r_acc[i] + COUNT_WIDTH'(1) : r_acc[i];

         if (i == 0) begin : g_ref
            assign w_match[i] = 1'b1;
         end else begin : g_cmp
            logic [COUNT_WIDTH:0] w_diff;
            logic [COUNT_WIDTH:0] w_abs;
            assign w_diff     = {1'b0, w_acc_nxt[i]} - {1'b0, w_acc_nxt[0]};
            assign w_abs      = w_diff[COUNT_WIDTH] ? -w_diff : w_diff;
            assign w_match[i] = (w_abs <= c_tol);
         end
      end
   endgenerate

   assign w_gate_end   = (r_gate_cnt == c_gate_last);
   assign w_pass       = (&w_match) & ~(|w_ovf_nxt);
   assign w_streak_nxt = (r_streak == c_streak_full) ? r_streak : r_streak + c_streak_w'(1);

   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         r_state     <= S_IDLE;
         r_sample    <= '0;
         r_gate_cnt  <= '0;
         r_streak    <= '0;
         r_arm       <= '0;
         r_ovf       <= '0;
         r_acc       <= '0;
         freq_count  <= '0;
         overflow    <= '0;
         count_valid <= 1'b0;
         locked      <= 1'b0;
         lock_lost   <= 1'b0;
      end else begin
         r_sample    <= sample_in;
         count_valid <= 1'b0;
         lock_lost   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (enable) r_state <= S_ARM;
            end
            S_ARM: begin
               r_arm      <= '0;
               r_ovf      <= '0;
               r_acc      <= '0;
               r_gate_cnt <= '0;
               r_state    <= S_MEASURE;
            end
            S_MEASURE: begin
               if (!enable) begin
                  r_state  <= S_IDLE;
                  r_streak <= '0;
                  locked   <= 1'b0;
               end else begin
                  r_arm <= w_arm_nxt;
                  if (w_gate_end) begin
                     // Publish includes the terminal-cycle crossing; next gate starts at once.
                     freq_count  <= w_acc_nxt;
                     overflow    <= w_ovf_nxt;
                     count_valid <= 1'b1;
                     r_acc       <= '0;
                     r_ovf       <= '0;
                     r_gate_cnt  <= '0;
                     if (w_pass) begin
                        r_streak <= w_streak_nxt;
                        if (w_streak_nxt == c_streak_full) locked <= 1'b1;
                     end else begin
                        r_streak  <= '0;
                        locked    <= 1'b0;
                        lock_lost <= locked;
                     end
                  end else begin
                     r_acc      <= w_acc_nxt;
                     r_ovf      <= w_ovf_nxt;
                     r_gate_cnt <= r_gate_cnt + c_gate_w'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_freq_lock_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_lock_meter
// Purpose  : Scoreboard bench for freq_lock_meter (32-bit and 4-bit counters).
// Revision : 1.0  initial release
// ============================================================================
module tb_freq_lock_meter;

   localparam int DW   = 14;
   localparam int CH   = 2;
   localparam int CW   = 32;
   localparam int CWS  = 4;
   localparam int GATE = 100;

   logic               clock = 1'b0;
   logic               Reset;
   logic               enable;
   logic               enable_s;
   logic [CH*DW-1:0]   sample_in;
   logic [CH*DW-1:0]   sample_s;
   logic [CH*CW-1:0]   freq_count;
   logic               count_valid;
   logic [CH-1:0]      overflow;
   logic               locked;
   logic               lock_lost;
   logic [CH*CWS-1:0]  freq_count_s;
   logic               count_valid_s;
   logic [CH-1:0]      overflow_s;
   logic               locked_s;
   logic               lock_lost_s;

   always #5 clock = ~clock;

   freq_lock_meter #(
      .DATA_WIDTH(DW), .CHANNELS(CH), .COUNT_WIDTH(CW), .GATE_CYCLES(GATE),
      .HYST(64), .LOCK_TOL(2), .LOCK_GATES(4)
   ) dut (
      .clock(clock), .Reset(Reset), .enable(enable), .sample_in(sample_in),
      .freq_count(freq_count), .count_valid(count_valid), .overflow(overflow),
      .locked(locked), .lock_lost(lock_lost)
   );

   freq_lock_meter #(
      .DATA_WIDTH(DW), .CHANNELS(CH), .COUNT_WIDTH(CWS), .GATE_CYCLES(GATE),
      .HYST(64), .LOCK_TOL(2), .LOCK_GATES(4)
   ) dut_sat (
      .clock(clock), .Reset(Reset), .enable(enable_s), .sample_in(sample_s),
      .freq_count(freq_count_s), .count_valid(count_valid_s), .overflow(overflow_s),
      .locked(locked_s), .lock_lost(lock_lost_s)
   );

   typedef struct {
      int         ph;
      int         c0;
      int         c1;
      logic [1:0] ovf;
      logic       lk;
      logic       ll;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   ph       = 0;
   int   n_sat    = 0;
   int   amp[CH];
   int   per[CH];
   logic rst_cfg;
   logic en_cfg;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (ph=%0d)", name, act, exp, ph);
      end
   endtask

   function automatic logic [DW-1:0] wave(input int a, input int p, input int t);
      int v;
      v = ((t % p) >= (p / 2)) ? a : -a;
      return DW'(v);
   endfunction

   // All inputs change on the falling edge; ph is the index of the vector just driven plus one.
   task automatic step();
      @(negedge clock);
      Reset    = rst_cfg;
      enable   = en_cfg;
      enable_s = 1'b1;
      for (int c = 0; c < CH; c++) sample_in[c*DW +: DW] = wave(amp[c], per[c], ph);
      sample_s = {wave(1000, 2, ph), wave(1000, 2, ph)};
      ph++;
   endtask

   task automatic run_until(input int target);
      while (ph < target) step();
   endtask

   task automatic expect_gate(input int p, input int c0, input int c1, input logic lk, input logic ll);
      exp_t e;
      e.ph = p; e.c0 = c0; e.c1 = c1; e.ovf = 2'b00; e.lk = lk; e.ll = ll;
      q.push_back(e);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_freq_count"}, freq_count, 0);
      chk({tag, "_count_valid"}, count_valid, 0);
      chk({tag, "_overflow"}, overflow, 0);
      chk({tag, "_locked"}, locked, 0);
      chk({tag, "_lock_lost"}, lock_lost, 0);
      chk({tag, "_sat_freq_count"}, freq_count_s, 0);
      chk({tag, "_sat_overflow"}, overflow_s, 0);
   endtask

   // Main-DUT monitor: every publish is matched against the next queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (lock_lost && !count_valid) begin
            checks++;
            failures++;
            $display("FAIL lock_lost_without_valid: got 1 expected 0 (ph=%0d)", ph);
         end
         if (count_valid) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_count_valid: got 1 expected 0 (ph=%0d)", ph);
            end else begin
               e = q.pop_front();
               chk("publish_time", ph, e.ph);
               chk("count_ch0", freq_count[CW-1:0], e.c0);
               chk("count_ch1", freq_count[2*CW-1:CW], e.c1);
               chk("overflow", overflow, e.ovf);
               chk("locked", locked, e.lk);
               chk("lock_lost", lock_lost, e.ll);
            end
         end
      end
   end

   // Saturating-DUT monitor: period-2 input always exceeds a 4-bit count.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (count_valid_s) begin
            n_sat++;
            chk("sat_count_ch0", freq_count_s[CWS-1:0], 15);
            chk("sat_count_ch1", freq_count_s[2*CWS-1:CWS], 15);
            chk("sat_overflow", overflow_s, 3);
            chk("sat_locked", locked_s, 0);
            chk("sat_lock_lost", lock_lost_s, 0);
         end
      end
   end

   initial begin
      Reset     = 1'b0;
      enable    = 1'b0;
      enable_s  = 1'b0;
      sample_in = '0;
      sample_s  = '0;
      rst_cfg   = 1'b0;
      en_cfg    = 1'b0;
      amp       = '{1000, 1000};
      per       = '{10, 10};

      repeat (4) step();
      check_zero("reset");
      rst_cfg = 1'b1;
      run_until(100);

      for (int n = 0; n < 5; n++) expect_gate(202 + 100*n, 10, 10, n >= 3, 1'b0);
      expect_gate(702, 10, 20, 1'b0, 1'b1);
      expect_gate(802, 10, 20, 1'b0, 1'b0);
      expect_gate(902, 10, 0, 1'b0, 1'b0);
      expect_gate(1002, 10, 0, 1'b0, 1'b0);
      for (int n = 0; n < 4; n++) expect_gate(1102 + 100*n, 10, 10, n == 3, 1'b0);
      en_cfg = 1'b1;

      run_until(602);
      per[1] = 5;
      run_until(801);
      amp[1] = 50;
      per[1] = 10;
      run_until(1001);
      amp[1] = 65;

      // Abort at gate cycle 50 of a locked run.
      run_until(1452);
      chk("locked_before_abort", locked, 1);
      en_cfg = 1'b0;
      run_until(1454);
      chk("abort_locked", locked, 0);
      chk("abort_lock_lost", lock_lost, 0);
      chk("abort_hold_ch0", freq_count[CW-1:0], 10);
      chk("abort_hold_ch1", freq_count[2*CW-1:CW], 10);

      for (int n = 0; n < 4; n++) expect_gate(1602 + 100*n, 10, 10, n == 3, 1'b0);
      run_until(1500);
      en_cfg = 1'b1;

      // Asynchronous reset in the middle of a measuring, locked run.
      run_until(1951);
      chk("locked_before_reset", locked, 1);
      #2;
      Reset   = 1'b0;
      rst_cfg = 1'b0;
      #1;
      check_zero("async_reset");
      expect_gate(2102, 10, 10, 1'b0, 1'b0);
      expect_gate(2202, 10, 10, 1'b0, 1'b0);
      run_until(2000);
      rst_cfg = 1'b1;
      run_until(2260);

      chk("scoreboard_drained", q.size(), 0);
      chk("sat_gates_seen", (n_sat >= 15) ? 1 : 0, 1);
      chk("sat_never_locked", locked_s, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
